// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Registers the memory-stage result,
// extracts/extends load data, drives the register-file write port and the
// execute forwarding path, and flags misaligned or illegal-width loads.
// Ports: clk_i, rst_ni (async, active-low); valid_i/ready_o handshake;
//   rd_data_i, is_load_i, funct3_i, addr_lo_i, rd_addr_i, reg_wr_en_i, stall_i;
//   rf_wr_en_o/rf_wr_addr_o/rf_wr_data_o; fwd_valid_o/fwd_rd_o/fwd_data_o;
//   exc_o/exc_cause_o (01 misaligned, 10 illegal width).
// Optional: define WB_INSTRET_EN to add instret_o, a retired-instruction count.
module writeback_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int INSTRET_W  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [XLEN-1:0]       rd_data_i,
    input  logic                  is_load_i,
    input  logic [2:0]            funct3_i,
    input  logic [2:0]            addr_lo_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  reg_wr_en_i,
    input  logic                  stall_i,
    output logic                  rf_wr_en_o,
    output logic [REG_ADDR_W-1:0] rf_wr_addr_o,
    output logic [XLEN-1:0]       rf_wr_data_o,
    output logic                  fwd_valid_o,
    output logic [REG_ADDR_W-1:0] fwd_rd_o,
    output logic [XLEN-1:0]       fwd_data_o,
    output logic                  exc_o,
    output logic [1:0]            exc_cause_o
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0]  instret_o
`endif
);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_ILL  = 2'b10;

    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic [1:0]            err;
    } wb_t;

    wb_t q;

    logic [5:0]      sh;
    logic [XLEN-1:0] sh_data;
    logic [XLEN-1:0] ext;
    logic [1:0]      err;
    logic            sz_b, sz_h, sz_w, sz_d;
    logic            retire, capture, ok;

    assign sh      = {addr_lo_i, 3'b000};
    assign sh_data = rd_data_i >> sh;

    assign sz_b = (funct3_i[1:0] == 2'b00);
    assign sz_h = (funct3_i[1:0] == 2'b01);
    assign sz_w = (funct3_i[1:0] == 2'b10);
    assign sz_d = (funct3_i[1:0] == 2'b11);

    // funct3[2] selects zero-extension; with size = double it is the
    // illegal 111 encoding, which outranks misalignment.
    always_comb begin
        ext = rd_data_i;
        err = ERR_NONE;
        if (is_load_i) begin
            unique case (1'b1)
                sz_b: begin
                    ext = funct3_i[2] ?
                        {{(XLEN-8){1'b0}}, sh_data[7:0]} :
                        {{(XLEN-8){sh_data[7]}}, sh_data[7:0]};
                end
                sz_h: begin
                    ext = funct3_i[2] ?
                        {{(XLEN-16){1'b0}}, sh_data[15:0]} :
                        {{(XLEN-16){sh_data[15]}}, sh_data[15:0]};
                    if (addr_lo_i[0]) err = ERR_MIS;
                end
                sz_w: begin
                    ext = funct3_i[2] ?
                        {{(XLEN-32){1'b0}}, sh_data[31:0]} :
                        {{(XLEN-32){sh_data[31]}}, sh_data[31:0]};
                    if (|addr_lo_i[1:0]) err = ERR_MIS;
                end
                sz_d: begin
                    ext = rd_data_i;
                    if (funct3_i[2])     err = ERR_ILL;
                    else if (|addr_lo_i) err = ERR_MIS;
                end
                default: ;
            endcase
        end
    end

    assign ready_o = !q.vld || !stall_i;
    assign capture = valid_i && ready_o;
    assign retire  = q.vld && !stall_i;
    assign ok      = q.wr && (q.rd != '0) && (q.err == ERR_NONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q <= '0;
        end else if (capture) begin
            q.vld  <= 1'b1;
            q.wr   <= reg_wr_en_i;
            q.rd   <= rd_addr_i;
            q.data <= ext;
            q.err  <= err;
        end else if (retire) begin
            q.vld <= 1'b0;
        end
    end

    assign rf_wr_en_o   = retire && ok;
    assign rf_wr_addr_o = q.rd;
    assign rf_wr_data_o = q.data;
    assign fwd_valid_o  = q.vld && ok;
    assign fwd_rd_o     = q.rd;
    assign fwd_data_o   = q.data;
    assign exc_o        = retire && (q.err != ERR_NONE);
    assign exc_cause_o  = exc_o ? q.err : ERR_NONE;

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_o <= '0;
        end else if (retire && (q.err == ERR_NONE)) begin
            instret_o <= instret_o + 1'b1;
        end
    end
`endif

endmodule
